// File: rtl/modn_cascade_counter_pkg.sv
// Shared definitions for the modulo-N cascade counter: digit width helper,
// parameter limits and the count direction encoding.
package modn_counter_pkg;

    localparam int MAX_MOD    = 256;
    localparam int MAX_DIGITS = 8;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

    // Bits needed to hold one digit of value 0..mod-1, never less than one.
    function automatic int digit_width(input int mod);
        int w;
        w = $clog2(mod);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/modn_cascade_counter_if.sv
// Control/status bundle of the modulo-N cascade counter.
// master drives the controls and observes the count, slave is the counter.
interface modn_cascade_counter_if
    import modn_counter_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int DIG_W  = digit_width(10)
);
    logic                      en;
    logic                      up_dn;
    logic                      load;
    logic [DIGITS*DIG_W-1:0]   load_val;
    logic [DIGITS*DIG_W-1:0]   count;
    logic                      tc;
    logic                      wrap;
    logic                      load_err;

    modport master (
        output en, up_dn, load, load_val,
        input  count, tc, wrap, load_err
    );

    modport slave (
        input  en, up_dn, load, load_val,
        output count, tc, wrap, load_err
    );
endinterface

// File: rtl/modn_cascade_counter_digit.sv
// One mod-MOD digit register of the cascade. Steps up or down when its
// carry/borrow input is set; a load replaces out-of-range fields with 0.
module modn_digit
    import modn_counter_pkg::*;
#(
    parameter int MOD   = 10,
    parameter int DIG_W = digit_width(MOD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DIG_W-1:0] load_digit,
    input  logic             step,
    input  logic             up_dn,
    output logic [DIG_W-1:0] value,
    output logic             at_max,
    output logic             at_min,
    output logic             bad_load
);
    localparam logic [DIG_W-1:0] MAXV = DIG_W'(MOD - 1);
    // One extra bit so MOD = 2**DIG_W is still representable.
    localparam logic [DIG_W:0]   MODV = (DIG_W + 1)'(MOD);

    logic field_bad;

    assign field_bad = ({1'b0, load_digit} >= MODV);
    assign bad_load  = load & field_bad;
    assign at_max    = (value == MAXV);
    assign at_min    = (value == '0);

    // Digit register: reset > load > step > hold, wrapping inside 0..MOD-1.
    always_ff @(posedge clk) begin
        if (!rst) begin
            value <= '0;
        end else if (load) begin
            value <= field_bad ? '0 : load_digit;
        end else if (step) begin
            if (dir_t'(up_dn) == DIR_UP)
                value <= at_max ? '0 : value + 1'b1;
            else
                value <= at_min ? MAXV : value - 1'b1;
        end
    end

endmodule

// File: rtl/modn_cascade_counter.sv
// Multi-digit modulo-MOD up/down counter built from DIGITS modn_digit cells
// joined by a same-cycle carry/borrow chain.
// Build option MODN_CASCADE_SATURATE_EN: counting stops at all-(MOD-1) going
// up or all-0 going down instead of wrapping, and wrap stays 0.
module modn_cascade_counter
    import modn_counter_pkg::*;
#(
    parameter int MOD    = 10,
    parameter int DIGITS = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    modn_cascade_counter_if.slave   bus
);
    localparam int DIG_W = digit_width(MOD);

    logic [DIGITS*DIG_W-1:0] count_q;
    logic [DIGITS-1:0]       at_max;
    logic [DIGITS-1:0]       at_min;
    logic [DIGITS-1:0]       bad_load;
    logic [DIGITS-1:0]       step;
    logic                    is_up;
    logic                    tc;
    logic                    cnt_en;
    logic                    chain;
    logic                    load_err_q;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        modn_digit #(
            .MOD   (MOD),
            .DIG_W (DIG_W)
        ) u_digit (
            .clk        (clk),
            .rst        (rst),
            .load       (bus.load),
            .load_digit (bus.load_val[i*DIG_W +: DIG_W]),
            .step       (step[i]),
            .up_dn      (bus.up_dn),
            .value      (count_q[i*DIG_W +: DIG_W]),
            .at_max     (at_max[i]),
            .at_min     (at_min[i]),
            .bad_load   (bad_load[i])
        );
    end

    assign is_up = (dir_t'(bus.up_dn) == DIR_UP);
    assign tc    = bus.en & (is_up ? (&at_max) : (&at_min));

`ifdef MODN_CASCADE_SATURATE_EN
    // At the terminal value the whole chain is frozen, so the count sticks.
    assign cnt_en   = bus.en & ~tc;
    assign bus.wrap = 1'b0;
`else
    logic wrap_q;

    assign cnt_en   = bus.en;
    assign bus.wrap = wrap_q;

    // A step taken at the terminal value is the full-range wrap; load and reset win.
    always_ff @(posedge clk) begin
        if (!rst)
            wrap_q <= 1'b0;
        else
            wrap_q <= ~bus.load & tc;
    end
`endif

    // Ripple carry/borrow: digit i steps when every lower digit is at its limit.
    always_comb begin
        step  = '0;
        chain = cnt_en;
        for (int i = 0; i < DIGITS; i++) begin
            step[i] = chain;
            chain   = chain & (is_up ? at_max[i] : at_min[i]);
        end
    end

    // One-cycle flag after a load that carried any out-of-range digit.
    always_ff @(posedge clk) begin
        if (!rst)
            load_err_q <= 1'b0;
        else
            load_err_q <= |bad_load;
    end

    assign bus.count    = count_q;
    assign bus.tc       = tc;
    assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_modn_cascade_counter.sv
// Bench for modn_cascade_counter: a directed vector table followed by random
// stimulus, both checked against an integer-valued reference model.
module tb_modn_cascade_counter;
    import modn_counter_pkg::*;

`ifdef MODN_CASCADE_SATURATE_EN
    localparam int MOD    = 6;
    localparam int DIGITS = 3;
    localparam bit SAT    = 1'b1;
`else
    localparam int MOD    = 10;
    localparam int DIGITS = 2;
    localparam bit SAT    = 1'b0;
`endif
    localparam int DW = digit_width(MOD);
    localparam int LW = DIGITS * DW;
    localparam int TOT = MOD ** DIGITS;

    typedef struct {
        logic          r;
        logic          e;
        logic          u;
        logic          l;
        logic [LW-1:0] lv;
        int            rep;
        logic          tc;
        logic [LW-1:0] cnt;
        logic          w;
        logic          err;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    int   m_n = 0;
    bit   m_w = 1'b0;
    bit   m_err = 1'b0;
    bit   m_valid = 1'b0;

    vec_t tbl[$];

    modn_cascade_counter_if #(.DIGITS(DIGITS), .DIG_W(DW)) bus ();

    modn_cascade_counter #(.MOD(MOD), .DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] pack(input int n);
        logic [LW-1:0] v;
        int p;
        v = '0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            v[i*DW +: DW] = DW'((n / p) % MOD);
            p = p * MOD;
        end
        return v;
    endfunction

    function automatic bit model_tc(input logic e, input logic u);
        return e && (u ? (m_n == TOT - 1) : (m_n == 0));
    endfunction

    task automatic model_edge(input logic r, input logic e, input logic u,
                              input logic l, input logic [LW-1:0] lv);
        int p;
        int f;
        m_w = 1'b0;
        m_err = 1'b0;
        if (!r) begin
            m_n = 0;
            m_valid = 1'b1;
        end else if (l) begin
            m_n = 0;
            p = 1;
            for (int i = 0; i < DIGITS; i++) begin
                f = int'(lv[i*DW +: DW]);
                if (f >= MOD) begin
                    f = 0;
                    m_err = 1'b1;
                end
                m_n = m_n + f * p;
                p = p * MOD;
            end
        end else if (e) begin
            if (u) begin
                if (m_n == TOT - 1) begin
                    if (!SAT) begin
                        m_n = 0;
                        m_w = 1'b1;
                    end
                end else begin
                    m_n = m_n + 1;
                end
            end else begin
                if (m_n == 0) begin
                    if (!SAT) begin
                        m_n = TOT - 1;
                        m_w = 1'b1;
                    end
                end else begin
                    m_n = m_n - 1;
                end
            end
        end
    endtask

    // Drive one cycle of inputs, check tc before the edge and registered outputs after it.
    task automatic drive(input logic r, input logic e, input logic u, input logic l,
                         input logic [LW-1:0] lv, output logic tc_seen);
        rst          = r;
        bus.en       = e;
        bus.up_dn    = u;
        bus.load     = l;
        bus.load_val = lv;
        #1;
        tc_seen = bus.tc;
        if (m_valid)
            check("tc_model", bus.tc, model_tc(e, u));
        @(posedge clk);
        model_edge(r, e, u, l, lv);
        @(negedge clk);
        check("count_model", bus.count, pack(m_n));
        check("wrap_model", bus.wrap, m_w);
        check("load_err_model", bus.load_err, m_err);
    endtask

    task automatic add(input logic r, input logic e, input logic u, input logic l,
                       input logic [LW-1:0] lv, input int rep, input logic tc,
                       input logic [LW-1:0] cnt, input logic w, input logic err);
        vec_t v;
        v.r = r; v.e = e; v.u = u; v.l = l; v.lv = lv; v.rep = rep;
        v.tc = tc; v.cnt = cnt; v.w = w; v.err = err;
        tbl.push_back(v);
    endtask

    initial begin
        logic tc_seen;
        int   up_pct;

        rst          = 1'b0;
        bus.en       = 1'b0;
        bus.up_dn    = 1'b1;
        bus.load     = 1'b0;
        bus.load_val = '0;

`ifdef MODN_CASCADE_SATURATE_EN
        //   r  e  u  l  load_val  rep tc  count     w  err
        add(0, 1, 1, 1, LW'(9'o555), 2, 0, LW'(9'o000), 0, 0);
        add(1, 0, 1, 1, LW'(9'o555), 1, 0, LW'(9'o555), 0, 0);
        add(1, 1, 1, 0, '0,          4, 1, LW'(9'o555), 0, 0);
        add(1, 1, 0, 0, '0,          1, 0, LW'(9'o554), 0, 0);
        add(0, 0, 1, 0, '0,          1, 0, LW'(9'o000), 0, 0);
        add(1, 1, 0, 0, '0,          3, 1, LW'(9'o000), 0, 0);
        add(1, 1, 1, 0, '0,          1, 0, LW'(9'o001), 0, 0);
        add(1, 0, 1, 1, LW'(9'o707), 1, 0, LW'(9'o000), 0, 1);
        add(1, 0, 1, 1, LW'(9'o056), 1, 0, LW'(9'o050), 0, 1);
        add(1, 1, 1, 0, '0,          1, 0, LW'(9'o051), 0, 0);
`else
        //   r  e  u  l  load_val rep tc count   w  err
        add(0, 1, 1, 1, LW'(8'h47), 2, 0, LW'(8'h00), 0, 0);
        add(1, 1, 1, 0, '0,        98, 0, LW'(8'h98), 0, 0);
        add(1, 1, 1, 0, '0,         1, 0, LW'(8'h99), 0, 0);
        add(1, 1, 1, 0, '0,         1, 1, LW'(8'h00), 1, 0);
        add(1, 1, 0, 0, '0,         1, 1, LW'(8'h99), 1, 0);
        add(1, 1, 0, 0, '0,         8, 0, LW'(8'h91), 0, 0);
        add(1, 1, 0, 0, '0,         1, 0, LW'(8'h90), 0, 0);
        add(1, 1, 0, 0, '0,         1, 0, LW'(8'h89), 0, 0);
        add(1, 1, 0, 1, LW'(8'h47), 1, 0, LW'(8'h47), 0, 0);
        add(1, 1, 1, 0, '0,         3, 0, LW'(8'h50), 0, 0);
        add(1, 0, 1, 0, '0,         5, 0, LW'(8'h50), 0, 0);
        add(1, 0, 1, 1, LW'(8'hC3), 1, 0, LW'(8'h03), 0, 1);
        add(1, 0, 1, 0, '0,         1, 0, LW'(8'h03), 0, 0);
        add(0, 1, 1, 1, LW'(8'hC3), 1, 0, LW'(8'h00), 0, 0);
        add(1, 0, 1, 1, LW'(8'h37), 1, 0, LW'(8'h37), 0, 0);
        add(1, 1, 1, 0, '0,         1, 0, LW'(8'h38), 0, 0);
        add(1, 1, 0, 0, '0,         1, 0, LW'(8'h37), 0, 0);
        add(1, 1, 1, 0, '0,         1, 0, LW'(8'h38), 0, 0);
        add(1, 0, 1, 1, LW'(8'h56), 1, 0, LW'(8'h56), 0, 0);
        add(0, 1, 1, 0, '0,         1, 0, LW'(8'h00), 0, 0);
        add(1, 0, 1, 1, LW'(8'h9A), 1, 0, LW'(8'h90), 0, 1);
        add(1, 0, 1, 1, LW'(8'h99), 1, 0, LW'(8'h99), 0, 0);
        add(1, 0, 1, 0, '0,         1, 0, LW'(8'h99), 0, 0);
        add(1, 1, 1, 1, LW'(8'h00), 1, 1, LW'(8'h00), 0, 0);
`endif

        foreach (tbl[k]) begin
            for (int j = 0; j < tbl[k].rep; j++)
                drive(tbl[k].r, tbl[k].e, tbl[k].u, tbl[k].l, tbl[k].lv, tc_seen);
            check($sformatf("tbl%0d_tc", k), tc_seen, tbl[k].tc);
            check($sformatf("tbl%0d_count", k), bus.count, tbl[k].cnt);
            check($sformatf("tbl%0d_wrap", k), bus.wrap, tbl[k].w);
            check($sformatf("tbl%0d_load_err", k), bus.load_err, tbl[k].err);
        end

        // Random phases with different direction bias so both wrap points get hit.
        for (int ph = 0; ph < 4; ph++) begin
            up_pct = (ph % 2 == 0) ? 90 : 10;
            for (int c = 0; c < 250; c++) begin
                drive(($urandom_range(0, 39) != 0),
                      ($urandom_range(0, 4) != 0),
                      ($urandom_range(0, 99) < up_pct),
                      ($urandom_range(0, 19) == 0),
                      LW'($urandom),
                      tc_seen);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
